// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd F(2x2,3x3) datapath: tile geometry,
// the default tile type and the shift/saturate helper also used by Trans_Y.
package winograd_pkg;

  localparam int TILE     = 4;
  localparam int OUT_TILE = 2;
  localparam int DATA_W   = 16;
  localparam int SAT_W    = 64;

  typedef logic signed [DATA_W-1:0] tile_t [0:TILE-1][0:TILE-1];

  // Arithmetic shift (floor toward -inf) then clamp to a signed width-bit range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac_width,
    input int                      width
  );
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    shifted = acc >>> frac_width;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (width - 1));
    if (shifted > max_v) begin
      sat_shift = max_v;
    end else if (shifted < min_v) begin
      sat_shift = min_v;
    end else begin
      sat_shift = shifted;
    end
  endfunction

endpackage

// File: rtl/winograd_mac_lane.sv
// One tile element: product register, wide accumulator and the
// shift/saturate output register. All sequencing comes from the parent.
module winograd_mac_lane
  import winograd_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int ACC_W      = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    advance,
  input  logic                    first,
  input  logic                    write_out,
  input  logic signed [WIDTH-1:0] u,
  input  logic signed [WIDTH-1:0] v,
  output logic signed [WIDTH-1:0] m
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [SAT_W-1:0]   acc_wide;

  assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign acc_next = first ? prod_ext : acc + prod_ext;
  assign acc_wide = {{(SAT_W-ACC_W){acc_next[ACC_W-1]}}, acc_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      acc  <= '0;
      m    <= '0;
    end else begin
      if (load) begin
        prod <= u * v;
      end
      if (advance) begin
        acc <= acc_next;
      end
      // The output takes the final sum directly, not the registered acc.
      if (write_out) begin
        m <= WIDTH'(sat_shift(acc_wide, FRAC_WIDTH, WIDTH));
      end
    end
  end

endmodule

// File: rtl/winograd_ewmm_accum.sv
// Element-wise U*V multiply-accumulate over CHANNELS beats, emitting one
// fixed-point 4x4 tile M per CHANNELS accepted beats.
module winograd_ewmm_accum
  import winograd_pkg::*;
#(
  parameter int width      = 16,
  parameter int rows       = 4,
  parameter int cols       = 4,
  parameter int FRAC_WIDTH = 8,
  parameter int CHANNELS   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [width-1:0] U [0:rows-1][0:cols-1],
  input  logic signed [width-1:0] V [0:rows-1][0:cols-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [width-1:0] M [0:rows-1][0:cols-1]
);

  localparam int ACC_W = 2*width + $clog2(CHANNELS) + 1;
  localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Handshakes: a transfer happens on an edge where valid && ready; valid
  // never waits for ready, and a source holds its payload until transfer.
  logic             accept;
  logic             stall;
  logic             advance;
  logic             retire_last;
  logic             tag_first;
  logic             tag_last;
  logic [CNT_W-1:0] ch_cnt;
  logic             prod_valid;
  logic             prod_first;
  logic             prod_last;

  assign stall       = prod_valid && prod_last && out_valid && !out_ready;
  assign in_ready    = !stall;
  assign accept      = in_valid && in_ready;
  assign advance     = prod_valid && !stall;
  assign retire_last = advance && prod_last;
  assign tag_first   = (ch_cnt == '0);
  assign tag_last    = (ch_cnt == CNT_W'(CHANNELS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt     <= '0;
      prod_valid <= 1'b0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (accept) begin
        ch_cnt     <= tag_last ? '0 : ch_cnt + 1'b1;
        prod_valid <= 1'b1;
        prod_first <= tag_first;
        prod_last  <= tag_last;
      end else if (advance) begin
        prod_valid <= 1'b0;
      end
      // A new result keeps out_valid high even when the old one is taken.
      if (retire_last) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < rows; i++) begin : g_row
    for (genvar j = 0; j < cols; j++) begin : g_col
      winograd_mac_lane #(
        .WIDTH      (width),
        .FRAC_WIDTH (FRAC_WIDTH),
        .ACC_W      (ACC_W)
      ) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .advance   (advance),
        .first     (prod_first),
        .write_out (retire_last),
        .u         (U[i][j]),
        .v         (V[i][j]),
        .m         (M[i][j])
      );
    end
  end

endmodule

// File: tb/tb_winograd_ewmm_accum.sv
// Bench for winograd_ewmm_accum: directed tiles with literal results plus
// randomized streaming against a behavioural sum-of-products model.
module tb_winograd_ewmm_accum;
  import winograd_pkg::*;

  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [15:0] U [0:3][0:3];
  logic signed [15:0] V [0:3][0:3];
  logic signed [15:0] M [0:3][0:3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int deliveries = 0;
  int last_acc_cyc = -100;
  int deliv_cyc[$];
  int m_ch = 0;
  longint sum [0:3][0:3];
  logic [255:0] exp_q[$];
  logic [255:0] last_m = '0;
  logic [255:0] prev_m = '0;
  logic prev_hold = 1'b0;
  logic prev_valid = 1'b0;
  logic lat_en = 1'b0;
  logic saw_stall = 1'b0;
  logic forced_ready = 1'b1;
  logic rand_en = 1'b0;

  always #5 clk = ~clk;

  winograd_ewmm_accum #(
    .width(16), .rows(4), .cols(4), .FRAC_WIDTH(8), .CHANNELS(CH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .U(U), .V(V), .out_valid(out_valid), .out_ready(out_ready), .M(M)
  );

  function automatic logic [255:0] flat(input tile_t t);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[(i*4+j)*16 +: 16] = t[i][j];
    return r;
  endfunction

  // Fixed-point value of a raw sum: floor(s / 2^8), clamped to 16 bits.
  function automatic logic [15:0] ref_elem(input longint s);
    longint q;
    q = s / 256;
    if ((s % 256) != 0 && s < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  // Downstream ready: random in the soak phase, otherwise forced.
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = rand_en ? 1'($urandom_range(0, 1)) : forced_ready;
  end

  // Model + compare process, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_ch = 0;
      exp_q.delete();
      prev_hold = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (!(out_valid && flat(M) == prev_m)) begin
          failures++;
          $display("FAIL hold_m cyc=%0d got valid=%0b m=%h want valid=1 m=%h", cyc, out_valid, flat(M), prev_m);
        end
      end
      if (!in_ready) begin
        saw_stall = 1'b1;
        checks++;
        if (!(out_valid && !out_ready)) begin
          failures++;
          $display("FAIL in_ready_low cyc=%0d got out_valid=%0b out_ready=%0b want 1/0", cyc, out_valid, out_ready);
        end
      end
      if (lat_en && out_valid && !prev_valid) begin
        checks++;
        if (cyc - last_acc_cyc != 2) begin
          failures++;
          $display("FAIL latency got=%0d want=2", cyc - last_acc_cyc);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL tile_unexpected cyc=%0d got=%h want=none", cyc, flat(M));
        end else begin
          logic [255:0] e;
          e = exp_q.pop_front();
          if (flat(M) != e) begin
            failures++;
            $display("FAIL tile cyc=%0d got=%h want=%h", cyc, flat(M), e);
          end
        end
        deliveries++;
        deliv_cyc.push_back(cyc);
        last_m = flat(M);
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            sum[i][j] = (m_ch == 0 ? 64'sd0 : sum[i][j]) + longint'(U[i][j]) * longint'(V[i][j]);
        m_ch++;
        if (m_ch == CH) begin
          logic [255:0] e;
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
              e[(i*4+j)*16 +: 16] = ref_elem(sum[i][j]);
          exp_q.push_back(e);
          last_acc_cyc = cyc;
          m_ch = 0;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_m = flat(M);
      prev_valid = out_valid;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input tile_t u, input tile_t v);
    int budget;
    bit done;
    budget = 200;
    done = 1'b0;
    U = u;
    V = v;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        budget--;
        if (budget == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_accept got=timeout want=accept");
          done = 1'b1;
        end
      end
      sync();
    end
  endtask

  task automatic send_const_tile(input logic signed [15:0] uval, input logic signed [15:0] vval);
    tile_t u;
    tile_t v;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        u[i][j] = uval;
        v[i][j] = vval;
      end
    for (int b = 0; b < CH; b++) drive_beat(u, v);
    in_valid = 1'b0;
  endtask

  task automatic send_rand_beat(input bit gaps);
    tile_t u;
    tile_t v;
    bit wide;
    wide = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        u[i][j] = wide ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
        v[i][j] = wide ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
      end
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) sync();
    end
    drive_beat(u, v);
  endtask

  task automatic wait_deliv(input int n);
    int budget;
    budget = 400;
    while (deliveries < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (deliveries < n) begin
      checks++;
      failures++;
      $display("FAIL deliver_wait got=%0d want=%0d", deliveries, n);
    end
    #1;
  endtask

  task automatic check_lit(input string name, input logic signed [15:0] val);
    logic [255:0] e;
    for (int k = 0; k < 16; k++) e[k*16 +: 16] = val;
    checks++;
    if (last_m != e) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, last_m, e);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (!(in_ready == 1'b1 && out_valid == 1'b0 && flat(M) == '0)) begin
      failures++;
      $display("FAIL %s got in_ready=%0b out_valid=%0b m=%h want 1/0/0", name, in_ready, out_valid, flat(M));
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        U[i][j] = '0;
        V[i][j] = '0;
      end
    repeat (2) sync();
    @(negedge clk);
    check_reset_outputs("reset_state");
    sync();
    rst_n = 1'b1;
    sync();

    lat_en = 1'b1;
    n = deliveries;
    send_const_tile(16'sd256, 16'sd512);
    wait_deliv(n + 1);
    check_lit("basic_sum", 16'sd2048);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL out_valid_pulse got=%0b want=0", out_valid);
    end
    sync();
    lat_en = 1'b0;

    n = deliveries;
    send_const_tile(-16'sd384, 16'sd128);
    wait_deliv(n + 1);
    check_lit("negative", -16'sd768);

    n = deliveries;
    send_const_tile(16'sd25600, 16'sd25600);
    wait_deliv(n + 1);
    check_lit("sat_pos", 16'sd32767);

    n = deliveries;
    send_const_tile(-16'sd25600, 16'sd25600);
    wait_deliv(n + 1);
    check_lit("sat_neg", -16'sd32768);

    n = deliveries;
    send_const_tile(16'sd1, 16'sd1);
    wait_deliv(n + 1);
    check_lit("floor_pos", 16'sd0);

    n = deliveries;
    send_const_tile(-16'sd1, 16'sd1);
    wait_deliv(n + 1);
    check_lit("floor_neg", -16'sd1);

    // Backpressure: three tiles stream back to back while out_ready is low.
    forced_ready = 1'b0;
    repeat (2) sync();
    n = deliveries;
    saw_stall = 1'b0;
    fork
      begin
        for (int b = 0; b < 3 * CH; b++) send_rand_beat(1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (12) @(posedge clk);
        forced_ready = 1'b1;
      end
    join
    wait_deliv(n + 3);
    checks++;
    if (!saw_stall) begin
      failures++;
      $display("FAIL stall_seen got=0 want=1");
    end
    checks++;
    if (deliv_cyc.size() < n + 2 || deliv_cyc[n+1] - deliv_cyc[n] != 1) begin
      failures++;
      $display("FAIL second_after_release got=%0d want=1",
               deliv_cyc.size() < n + 2 ? -1 : deliv_cyc[n+1] - deliv_cyc[n]);
    end

    // Randomized soak with input gaps and random downstream ready.
    rand_en = 1'b1;
    n = deliveries;
    for (int t = 0; t < 30; t++)
      for (int b = 0; b < CH; b++) send_rand_beat(1'b1);
    in_valid = 1'b0;
    rand_en = 1'b0;
    wait_deliv(n + 30);

    // Reset in the middle of a tile discards the partial sum.
    repeat (3) sync();
    send_rand_beat(1'b0);
    send_rand_beat(1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid_tile");
    sync();
    rst_n = 1'b1;
    sync();
    n = deliveries;
    send_const_tile(16'sd256, 16'sd256);
    wait_deliv(n + 1);
    check_lit("after_reset", 16'sd1024);

    repeat (3) sync();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_tiles got=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
